// File: rtl/sha3_padder_gen.sv
// sha3_padder_gen: Keccak/SHA-3 multi-rate message padder, one lane per cycle.
// Optional blk_cnt output is built when SHA3_PADDER_BLKCNT_EN is defined.
module sha3_padder_gen #(
    parameter int W    = 64,
    parameter int NB_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [NB_W-1:0] in_nbytes,
    input  logic [1:0]      mode,
    input  logic [1:0]      sfx,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_blk_end,
    output logic            out_msg_end
`ifdef SHA3_PADDER_BLKCNT_EN
    ,
    output logic [31:0]     blk_cnt
`endif
);

    localparam int NBYTES = W / 8;
    localparam int CW = 6;
    localparam logic [NB_W-1:0] NB_FULL = NB_W'(NBYTES);
    localparam logic [W-1:0] TOP = {8'h80, {(W-8){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ABSORB,
        S_PAD
    } state_t;

    function automatic logic [CW-1:0] f_rate(input logic [1:0] m);
        logic [CW-1:0] r;
        case (m)
            2'd0:    r = CW'(1088 / W);
            2'd1:    r = CW'(576 / W);
            2'd2:    r = CW'(1344 / W);
            default: r = CW'(832 / W);
        endcase
        return r;
    endfunction

    function automatic logic [7:0] f_sfx(input logic [1:0] s);
        logic [7:0] b;
        case (s)
            2'd0:    b = 8'h01;
            2'd2:    b = 8'h1F;
            default: b = 8'h06;
        endcase
        return b;
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_lane;
    logic [CW-1:0]  r_rate;
    logic [7:0]     r_sfx;
    logic           r_pend;
    logic [W-1:0]   r_data;
    logic           r_valid;
    logic           r_blk;
    logic           r_msg;

    logic [CW-1:0]  w_rate;
    logic [7:0]     w_sfx;
    logic [CW-1:0]  w_lidx;
    logic           w_at_end;
    logic           w_free;
    logic           w_xfer;
    logic           w_acc;
    logic           w_start;
    logic           w_pad_ld;
    logic           w_full;
    logic [W-1:0]   w_last_word;
    logic           w_ld;
    logic [W-1:0]   w_d;
    logic           w_blk;
    logic           w_msg;
    logic           w_pend_nxt;

    // Outside a message the live mode/sfx inputs apply to the word being accepted.
    assign w_rate  = (r_state == S_IDLE) ? f_rate(mode) : r_rate;
    assign w_sfx   = (r_state == S_IDLE) ? f_sfx(sfx) : r_sfx;
    assign w_free  = ~r_valid | out_ready;
    assign w_xfer  = r_valid & out_ready;
    assign in_ready = rst & (r_state != S_PAD) & w_free;
    assign w_acc   = in_valid & in_ready;
    assign w_start = w_acc & (r_state == S_IDLE);
    assign w_full  = (in_nbytes >= NB_FULL);

    // Index of the lane that would be loaded into the output register now.
    assign w_lidx = r_valid ? (r_blk ? '0 : r_lane + CW'(1)) : r_lane;
    assign w_at_end = (w_lidx == w_rate - CW'(1));

    assign w_pad_ld = (r_state == S_PAD) & w_free & ~(r_valid & r_msg);

    always_comb begin
        w_last_word = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (NB_W'(i) < in_nbytes)
                w_last_word[8*i +: 8] = in_data[8*i +: 8];
            else if (NB_W'(i) == in_nbytes)
                w_last_word[8*i +: 8] = w_sfx;
        end
    end

    always_comb begin
        w_ld        = 1'b0;
        w_d         = r_data;
        w_blk       = r_blk;
        w_msg       = r_msg;
        w_pend_nxt  = r_pend;
        w_state_nxt = r_state;
        if (w_acc) begin
            w_ld  = 1'b1;
            w_blk = w_at_end;
            w_msg = 1'b0;
            if (!in_last) begin
                w_d         = in_data;
                w_state_nxt = S_ABSORB;
            end else if (w_full) begin
                // Suffix moves to byte 0 of the next lane, possibly a new block.
                w_d         = in_data;
                w_pend_nxt  = 1'b1;
                w_state_nxt = S_PAD;
            end else begin
                w_d         = w_last_word | (w_at_end ? TOP : '0);
                w_msg       = w_at_end;
                w_pend_nxt  = 1'b0;
                w_state_nxt = w_at_end ? S_IDLE : S_PAD;
            end
        end else if (w_pad_ld) begin
            w_ld       = 1'b1;
            w_d        = {{(W-8){1'b0}}, (r_pend ? r_sfx : 8'h00)} |
                         (w_at_end ? TOP : '0);
            w_blk      = w_at_end;
            w_msg      = w_at_end;
            w_pend_nxt = 1'b0;
        end
        if ((r_state == S_PAD) && w_xfer && r_msg)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rate <= '0;
            r_sfx  <= '0;
        end else if (w_start) begin
            r_rate <= f_rate(mode);
            r_sfx  <= f_sfx(sfx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_lane <= '0;
        else if (w_xfer)
            r_lane <= r_blk ? '0 : r_lane + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_blk   <= 1'b0;
            r_msg   <= 1'b0;
        end else if (w_ld) begin
            r_data  <= w_d;
            r_valid <= 1'b1;
            r_blk   <= w_blk;
            r_msg   <= w_msg;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
            r_blk   <= 1'b0;
            r_msg   <= 1'b0;
        end
    end

`ifdef SHA3_PADDER_BLKCNT_EN
    logic [31:0] r_blk_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_blk_cnt <= '0;
        else if (w_start)
            r_blk_cnt <= '0;
        else if (w_xfer && r_blk && (r_blk_cnt != 32'hFFFF_FFFF))
            r_blk_cnt <= r_blk_cnt + 32'd1;
    end

    assign blk_cnt = r_blk_cnt;
`endif

    assign out_data    = r_data;
    assign out_valid   = r_valid;
    assign out_blk_end = r_blk;
    assign out_msg_end = r_msg;

endmodule

// File: tb/tb_sha3_padder_gen.sv
// tb_sha3_padder_gen: directed vectors for the SHA-3 padder, W=64.
// Lanes are captured at the falling edge and compared to hand-built tables.
module tb_sha3_padder_gen;

    localparam logic [63:0] TOP = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [3:0]  in_nbytes;
    logic [1:0]  mode;
    logic [1:0]  sfx;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_blk_end;
    logic        out_msg_end;
`ifdef SHA3_PADDER_BLKCNT_EN
    logic [31:0] blk_cnt;
`endif

    sha3_padder_gen #(.W(64), .NB_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .in_nbytes   (in_nbytes),
        .mode        (mode),
        .sfx         (sfx),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_blk_end (out_blk_end),
        .out_msg_end (out_msg_end)
`ifdef SHA3_PADDER_BLKCNT_EN
        ,
        .blk_cnt     (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] q_d[$];
    logic [1:0]  q_f[$];
    logic [63:0] exp_d[0:63];
    logic [63:0] wd[0:4];
    int n_chk = 0;
    int n_err = 0;

    // A lane seen valid&ready at the falling edge transfers on the next rise.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            q_d.push_back(out_data);
            q_f.push_back({out_blk_end, out_msg_end});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] want);
        n_chk++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, want);
        end
    endtask

    task automatic start(input logic [1:0] m, input logic [1:0] s);
        q_d.delete();
        q_f.delete();
        for (int i = 0; i < 64; i++) exp_d[i] = '0;
        mode = m;
        sfx  = s;
    endtask

    task automatic send(input logic [63:0] d, input logic l, input logic [3:0] n);
        int t = 0;
        in_data   = d;
        in_last   = l;
        in_nbytes = n;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int nl);
        int t = 0;
        while (q_d.size() < nl && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic verify(input string tag, input int nl, input int rate);
        check({tag, "_cnt"}, 64'(q_d.size()), 64'(nl));
        for (int i = 0; i < nl && i < q_d.size(); i++) begin
            check($sformatf("%s_d%0d", tag, i), q_d[i], exp_d[i]);
            check($sformatf("%s_f%0d", tag, i), {62'd0, q_f[i]},
                  {62'd0, ((i % rate) == rate - 1), (i == nl - 1)});
        end
`ifdef SHA3_PADDER_BLKCNT_EN
        check({tag, "_blkcnt"}, 64'(blk_cnt), 64'(nl / rate));
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int t;
        int c0;
        rst = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_nbytes = '0;
        mode = '0;
        sfx = '0;
        out_ready = 1'b1;
        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_flags", 64'({out_blk_end, out_msg_end}), 64'd0);
        check("rst_inrdy", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_inrdy", 64'(in_ready), 64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // one short word, with junk input and a mode change during PAD
        start(2'd1, 2'd1);
        send(64'h0000_0000_00CC_BBAA, 1'b1, 4'd3);
        in_valid = 1'b1;
        in_data = '1;
        in_last = 1'b0;
        mode = 2'd0;
        sfx = 2'd2;
        @(negedge clk);
        check("t1_pad_inrdy", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(9);
        exp_d[0] = 64'h0000_0000_06CC_BBAA;
        exp_d[8] = TOP;
        verify("t1", 9, 9);

        // empty message, SHAKE suffix
        start(2'd1, 2'd2);
        send(64'h1122_3344_5566_7788, 1'b1, 4'd0);
        collect(9);
        exp_d[0] = 64'h0000_0000_0000_001F;
        exp_d[8] = TOP;
        verify("t2", 9, 9);

        // full last word on the final lane: one extra block
        start(2'd1, 2'd1);
        c0 = cyc;
        for (int i = 0; i < 9; i++)
            send(64'hA5A5_0000_0000_0000 | 64'(i), i == 8, 4'd8);
        check("t3_nobubble", 64'(cyc - c0), 64'd9);
        collect(18);
        for (int i = 0; i < 9; i++) exp_d[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        exp_d[9] = 64'h06;
        exp_d[17] = TOP;
        verify("t3", 18, 9);

        // suffix shares the top byte with 0x80
        start(2'd1, 2'd1);
        for (int i = 0; i < 8; i++) send(64'h5A00_0000_0000_0000 | 64'(i), 1'b0, 4'd0);
        send(64'h00FF_FFFF_FFFF_FFFF, 1'b1, 4'd7);
        collect(9);
        for (int i = 0; i < 8; i++) exp_d[i] = 64'h5A00_0000_0000_0000 | 64'(i);
        exp_d[8] = 64'h86FF_FFFF_FFFF_FFFF;
        verify("t4", 9, 9);

        // byte masking of a dirty last word, Keccak suffix, rate 17
        start(2'd0, 2'd0);
        send(64'hDEAD_BEEF_CAFE_1234, 1'b1, 4'd2);
        collect(17);
        exp_d[0] = 64'h0000_0000_0001_1234;
        exp_d[16] = TOP;
        verify("t5", 17, 17);

        // downstream stall for 5 cycles mid-block, rate 13
        start(2'd3, 2'd1);
        for (int i = 0; i < 4; i++) wd[i] = 64'h0123_4567_89AB_CDE0 | 64'(i);
        wd[4] = 64'h9988_7766_5544_3322;
        for (int i = 0; i < 4; i++) exp_d[i] = wd[i];
        exp_d[4] = 64'h0000_0006_5544_3322;
        exp_d[12] = TOP;
        fork
            begin
                for (int i = 0; i < 4; i++) send(wd[i], 1'b0, 4'd8);
                send(wd[4], 1'b1, 4'd4);
            end
            begin
                t = 0;
                while (q_d.size() < 2 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("t6_stall_d", out_data, exp_d[q_d.size()]);
                    check("t6_stall_v", 64'(out_valid), 64'd1);
                    check("t6_stall_inrdy", 64'(in_ready), 64'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        collect(13);
        verify("t6", 13, 13);

        // reset during PAD, then a clean message
        start(2'd1, 2'd1);
        send(64'h0000_0000_00CC_BBAA, 1'b1, 4'd3);
        t = 0;
        while (q_d.size() < 4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t7_pre_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t7_rst_valid", 64'(out_valid), 64'd0);
        check("t7_rst_data", out_data, 64'd0);
        check("t7_rst_flags", 64'({out_blk_end, out_msg_end}), 64'd0);
        check("t7_rst_inrdy", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        q_d.delete();
        q_f.delete();
        repeat (6) @(negedge clk);
        check("t7_residual", 64'(q_d.size()), 64'd0);
        @(posedge clk); #1;
        start(2'd0, 2'd1);
        send(64'h0000_0000_00CC_BBAA, 1'b1, 4'd3);
        collect(17);
        exp_d[0] = 64'h0000_0000_06CC_BBAA;
        exp_d[16] = TOP;
        verify("t7", 17, 17);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sha3_padder_gen.md
SHA3_PADDER_GEN -- requirements
Module: sha3_padder_gen

Interface
REQ-001 SHALL have parameter W, default 64, meaning lane width in bits (legal values 32, 64).
REQ-002 SHALL have parameter NB_W, default 4, meaning in_nbytes width (clog2(W/8)+1).
REQ-003 SHALL have port clk, input, 1, the single clock, with all state updating on its rising edge.
REQ-004 SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port in_data, input, W, the message lane, little-endian, with byte i at bits [8i+7:8i].
REQ-006 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-008 SHALL have port in_last, input, 1, marking the final word of the message.
REQ-009 SHALL have port in_nbytes, input, NB_W, giving the valid bytes of the last word (0..W/8) and ignored when in_last=0.
REQ-010 SHALL have port mode, input, 2, the rate select: 0 = 1088 bits, 1 = 576, 2 = 1344, 3 = 832.
REQ-011 SHALL have port sfx, input, 2, the domain suffix: 0 = 0x01 (Keccak), 1 = 0x06 (SHA3), 2 = 0x1F (SHAKE), 3 = reserved, treated as 0x06.
REQ-012 SHALL have port out_data, output, W, the padded lane.
REQ-013 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-014 SHALL have port out_ready, input, 1, meaning the downstream permutation accepts the lane.
REQ-015 SHALL have port out_blk_end, output, 1, asserted with the last lane of every rate block.
REQ-016 SHALL have port out_msg_end, output, 1, asserted with the last lane of the final block.

Function
REQ-017 SHALL compute the rate in lanes as RATE_BITS/W; mode and sfx SHALL be latched on the first accepted word of a message and held until out_msg_end is transferred.
REQ-018 SHALL implement the FSM IDLE -> ABSORB (first accepted word) -> PAD (in_last accepted and padding lanes remain) -> IDLE (out_msg_end transferred); when in_last completes the final block, the FSM SHALL go from ABSORB directly to IDLE.
REQ-019 SHALL keep a lane counter of 0..RATE-1 that increments on each output transfer and wraps to 0 after out_blk_end.
REQ-020 SHALL have a single output register: in_ready = (state != PAD) & (~out_valid | out_ready); a lane is transferred when out_valid & out_ready.
REQ-021 SHALL give a latency of one cycle from input acceptance to out_valid, with no bubbles under continuous valid/ready.
REQ-022 SHALL hold out_data, out_valid, out_blk_end and out_msg_end stable while out_valid & ~out_ready.
REQ-023 SHALL, for a non-last word, pass in_data through unchanged.
REQ-024 SHALL, for a last word with n < W/8, zero bytes n and above and OR the suffix byte into byte n.
REQ-025 SHALL, for a last word with n = W/8, pass the word unchanged and place the suffix byte in byte 0 of the next emitted lane.
REQ-026 SHALL make every PAD lane zero except for the suffix placement and the final 0x80.
REQ-027 SHALL OR 0x80 into byte W/8-1 of the last lane of the final block; if the suffix lands in that same byte, the byte SHALL be suffix|0x80 (e.g. 0x86).
REQ-028 SHALL, if a full last word lands on lane RATE-1, emit one extra complete block: suffix in lane 0 and 0x80 in lane RATE-1.
REQ-029 SHALL ignore mode/sfx changes mid-message, and SHALL ignore in_valid while in PAD.

Reset
REQ-030 SHALL, on rst low, immediately clear the state to IDLE, the lane counter to 0, out_data to 0, and out_valid, out_blk_end and out_msg_end to 0.
REQ-031 SHALL hold in_ready at 0 during reset and assert it in the first cycle after rst deasserts.
REQ-032 SHALL discard any partially padded message when reset is applied mid-operation; no residual lane SHALL be emitted.

Configuration
REQ-033 SHALL, with SHA3_PADDER_BLKCNT_EN defined, add output blk_cnt[31:0]: cleared by reset and at message start, incremented on each out_blk_end transfer, saturating at 0xFFFFFFFF.
REQ-034 SHALL, without SHA3_PADDER_BLKCNT_EN, omit the port and the counter entirely, with all other behaviour identical.

Verification
REQ-035 SHALL test W=64, mode 1, sfx 1, one word 0x0000000000CCBBAA with in_last, n=3 -> lane0 0x0000000006CCBBAA, lanes1-7 0, lane8 0x8000000000000000 with out_blk_end & out_msg_end.
REQ-036 SHALL test the empty message (in_last, n=0, mode 1, sfx 2) -> lane0 0x000000000000001F, lane8 0x8000000000000000, 9 lanes total.
REQ-037 SHALL test 9 full words in mode 1, the 9th last with n=8 -> 18 lanes; lane9 0x06, lane17 0x8000000000000000, out_blk_end on lanes 8 and 17, out_msg_end only on 17.
REQ-038 SHALL test 9 words in mode 1, the 9th last with n=7 and data 0x00FFFFFFFFFFFFFF -> lane8 0x86FFFFFFFFFFFFFF, single block.
REQ-039 SHALL test out_ready low for 5 cycles mid-block -> out_data stable, in_ready 0, no lane lost or duplicated, order preserved.
REQ-040 SHALL test rst pulsed low during PAD lane 4 -> outputs 0 immediately; the next message (mode 0, sfx 1) pads correctly to 17 lanes.
